bus_fifo_lvl: RTL and testbench
===============================

BUS_FIFO_LVL -- requirements
Module: bus_fifo_lvl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL provide parameter DEPTH, default 16: entry count, power of two, minimum 2, all DEPTH entries usable.
REQ-003 SHALL provide parameter AFULL_THRESH, default DEPTH-2: ALMOST_FULL asserts when LEVEL >= this value.
REQ-004 SHALL provide parameter AEMPTY_THRESH, default 2: ALMOST_EMPTY asserts when LEVEL <= this value.
REQ-005 SHALL provide port CLK  input  1  clock; all state updates on rising edge.
REQ-006 SHALL provide port RESET_N  input  1  reset, synchronous, active-low.
REQ-007 SHALL provide port FLUSH  input  1  synchronous empty request.
REQ-008 SHALL provide port DATA_STROBE  input  1  write request.
REQ-009 SHALL provide port DATA_IN  input  WIDTH  write data.
REQ-010 SHALL provide port DATA_ACK  input  1  read acknowledge (pop).
REQ-011 SHALL provide port DATA_READY  output  1  FIFO non-empty.
REQ-012 SHALL provide port DATA_OUT  output  WIDTH  head entry, first-word-fall-through.
REQ-013 SHALL provide port FULL  output  1  LEVEL == DEPTH.
REQ-014 SHALL provide port ALMOST_FULL  output  1  threshold flag.
REQ-015 SHALL provide port ALMOST_EMPTY  output  1  threshold flag.
REQ-016 SHALL provide port LEVEL  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 SHALL provide port OVERFLOW  output  1  sticky: write attempted while full.
REQ-018 SHALL provide port UNDERFLOW  output  1  sticky: ack attempted while empty.
REQ-019 SHALL provide port ERR_CLEAR  input  1  clears OVERFLOW and UNDERFLOW.

Function
REQ-020 SHALL hold write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0, plus a registered occupancy counter driving LEVEL.
REQ-021 SHALL accept a write when DATA_STROBE=1 and FULL=0: store DATA_IN at the write pointer, advance it.
REQ-022 SHALL perform a pop when DATA_ACK=1 and DATA_READY=0 is false (i.e. non-empty): advance the read pointer.
REQ-023 SHALL evaluate FULL and DATA_READY from the pre-edge state; a write while FULL is dropped even if DATA_ACK pops the same cycle.
REQ-024 SHALL write a word into an empty FIFO even when DATA_ACK=1 in the same cycle; that ACK is not a pop.
REQ-025 SHALL update LEVEL: +1 write only, -1 pop only, unchanged for both or neither.
REQ-026 SHALL present the new head on DATA_OUT the cycle after a write to an empty FIFO (one-cycle write-to-read latency).
REQ-027 SHALL drive DATA_OUT to all zeros whenever DATA_READY=0.
REQ-028 SHALL derive DATA_READY, FULL, ALMOST_FULL and ALMOST_EMPTY combinationally from LEVEL only.
REQ-029 SHALL set OVERFLOW on DATA_STROBE=1 with FULL=1, and UNDERFLOW on DATA_ACK=1 with DATA_READY=0; both hold until ERR_CLEAR or reset.
REQ-030 SHALL give a set event priority over ERR_CLEAR in the same cycle.
REQ-031 SHALL, on FLUSH=1, zero both pointers and LEVEL next cycle, ignoring same-cycle write and pop; sticky flags are unaffected.
REQ-032 SHALL leave memory contents unreset; only pointers, LEVEL and sticky flags are reset.

Reset
REQ-033 SHALL, while RESET_N=0 at a rising edge, clear pointers and LEVEL to 0 and OVERFLOW and UNDERFLOW to 0, overriding FLUSH and all other inputs.
REQ-034 SHALL, after reset, output DATA_READY=0, FULL=0, ALMOST_FULL=0, ALMOST_EMPTY=1, LEVEL=0, DATA_OUT=0.
REQ-035 SHALL discard all contents on reset asserted mid-operation, including when full.

Verification
REQ-036 SHALL cover fill/drain: WIDTH=8, DEPTH=16, write 0x01..0x10 -> FULL=1 and LEVEL=16; ack 16 times -> DATA_OUT sequence 0x01..0x10, then DATA_READY=0 and DATA_OUT=0x00.
REQ-037 SHALL cover thresholds: LEVEL stepped 0->16->0 -> ALMOST_FULL high exactly for LEVEL>=14, ALMOST_EMPTY high exactly for LEVEL<=2.
REQ-038 SHALL cover simultaneous events: at LEVEL=5, strobe+ack -> LEVEL stays 5 and order preserved; at FULL, strobe+ack -> LEVEL=15 and OVERFLOW=1; at empty, strobe+ack -> LEVEL=1 and UNDERFLOW=1.
REQ-039 SHALL cover wrap-around: 40 interleaved writes and pops holding LEVEL in 3..6 -> every word out equals the word in, in order.
REQ-040 SHALL cover flush and clear: at LEVEL=9, FLUSH with strobe -> LEVEL=0 next cycle and DATA_READY=0; ERR_CLEAR with a new overflow the same cycle -> OVERFLOW stays 1.
REQ-041 SHALL cover reset mid-operation: full FIFO with OVERFLOW=1, RESET_N low one edge -> all REQ-034 values.

Source files
------------

// File: rtl/bus_fifo_lvl.sv
// bus_fifo_lvl: first-word-fall-through FIFO with occupancy level, threshold flags and sticky error flags
module bus_fifo_lvl #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     FLUSH,
  input  logic                     DATA_STROBE,
  input  logic [WIDTH-1:0]         DATA_IN,
  input  logic                     DATA_ACK,
  output logic                     DATA_READY,
  output logic [WIDTH-1:0]         DATA_OUT,
  output logic                     FULL,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  input  logic                     ERR_CLEAR
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_LVL   = LW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_en, pop;

  // status flags depend only on the registered level
  assign LEVEL        = level_q;
  assign DATA_READY   = level_q != '0;
  assign FULL         = level_q == FULL_LVL;
  assign ALMOST_FULL  = level_q >= AF_LVL;
  assign ALMOST_EMPTY = level_q <= AE_LVL;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;
  assign DATA_OUT     = DATA_READY ? mem[rd_ptr_q] : '0;

  // accepted write/pop judged on pre-edge FULL/READY; flush overrides pointer and level motion
  always_comb begin
    wr_en    = DATA_STROBE && !FULL;
    pop      = DATA_ACK && DATA_READY;
    wr_ptr_d = FLUSH ? '0 : wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = FLUSH ? '0 : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = FLUSH ? '0 : (wr_en && !pop) ? level_q + 1'b1 : (pop && !wr_en) ? level_q - 1'b1 : level_q;
    ovf_d    = (DATA_STROBE && FULL) || (ovf_q && !ERR_CLEAR);
    udf_d    = (DATA_ACK && !DATA_READY) || (udf_q && !ERR_CLEAR);
  end

  // state registers; reset beats flush and everything else
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // storage array is deliberately left unreset
  always_ff @(posedge CLK) begin
    if (RESET_N && wr_en && !FLUSH) mem[wr_ptr_q] <= DATA_IN;
  end
endmodule

// File: tb/tb_bus_fifo_lvl.sv
// tb_bus_fifo_lvl: directed self-checking bench for bus_fifo_lvl
module tb_bus_fifo_lvl;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       FLUSH = 1'b0;
  logic       DATA_STROBE = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       DATA_ACK = 1'b0;
  logic       ERR_CLEAR = 1'b0;
  logic       DATA_READY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [7:0] DATA_OUT;
  logic [4:0] LEVEL;
  int checks = 0;
  int errors = 0;

  bus_fifo_lvl #(.WIDTH(8), .DEPTH(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .DATA_STROBE(DATA_STROBE),
    .DATA_IN(DATA_IN), .DATA_ACK(DATA_ACK), .DATA_READY(DATA_READY),
    .DATA_OUT(DATA_OUT), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW), .ERR_CLEAR(ERR_CLEAR)
  );

  always #5 CLK = ~CLK;

  task automatic cycle(input logic s, input logic a, input logic [7:0] d);
    DATA_STROBE = s;
    DATA_ACK = a;
    DATA_IN = d;
    @(posedge CLK);
    #1;
    DATA_STROBE = 1'b0;
    DATA_ACK = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (DATA_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", DATA_READY); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", FULL); end
    checks++; if (ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL rst_afull got %b exp 0", ALMOST_FULL); end
    checks++; if (ALMOST_EMPTY !== 1'b1) begin errors++; $display("FAIL rst_aempty got %b exp 1", ALMOST_EMPTY); end
    checks++; if (LEVEL !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", LEVEL); end
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL rst_dout got %h exp 00", DATA_OUT); end
    checks++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", OVERFLOW, UNDERFLOW); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 1) begin
        checks++; if (DATA_READY !== 1'b1 || DATA_OUT !== 8'h01) begin errors++; $display("FAIL fwft_first got %b/%h exp 1/01", DATA_READY, DATA_OUT); end
      end
    end
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", FULL); end
    checks++; if (LEVEL !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", LEVEL); end
    for (int i = 1; i <= 16; i++) begin
      checks++; if (DATA_OUT !== 8'(i)) begin errors++; $display("FAIL drain_data got %h exp %h", DATA_OUT, 8'(i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    checks++; if (DATA_READY !== 1'b0) begin errors++; $display("FAIL drain_ready got %b exp 0", DATA_READY); end
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL drain_dout got %h exp 00", DATA_OUT); end
  endtask

  task automatic test_thresholds();
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) cycle(1'b1, 1'b0, 8'(n + 8'h40));
      checks++; if (LEVEL !== 5'(n)) begin errors++; $display("FAIL thr_up_level got %0d exp %0d", LEVEL, n); end
      checks++; if (ALMOST_FULL !== (n >= 14)) begin errors++; $display("FAIL thr_up_afull lvl %0d got %b", n, ALMOST_FULL); end
      checks++; if (ALMOST_EMPTY !== (n <= 2)) begin errors++; $display("FAIL thr_up_aempty lvl %0d got %b", n, ALMOST_EMPTY); end
    end
    for (int n = 15; n >= 0; n--) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (LEVEL !== 5'(n)) begin errors++; $display("FAIL thr_dn_level got %0d exp %0d", LEVEL, n); end
      checks++; if (ALMOST_FULL !== (n >= 14)) begin errors++; $display("FAIL thr_dn_afull lvl %0d got %b", n, ALMOST_FULL); end
      checks++; if (ALMOST_EMPTY !== (n <= 2)) begin errors++; $display("FAIL thr_dn_aempty lvl %0d got %b", n, ALMOST_EMPTY); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i));
    cycle(1'b1, 1'b1, 8'hA5);
    checks++; if (LEVEL !== 5'd5) begin errors++; $display("FAIL sim5_level got %0d exp 5", LEVEL); end
    for (int i = 1; i <= 5; i++) begin
      checks++; if (DATA_OUT !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL sim5_order got %h exp %h", DATA_OUT, 8'hA0 + 8'(i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'hB0 + 8'(i));
    cycle(1'b1, 1'b1, 8'hEE);
    checks++; if (LEVEL !== 5'd15) begin errors++; $display("FAIL simfull_level got %0d exp 15", LEVEL); end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL simfull_ovf got %b exp 1", OVERFLOW); end
    checks++; if (DATA_OUT !== 8'hB1) begin errors++; $display("FAIL simfull_head got %h exp b1", DATA_OUT); end
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h77);
    checks++; if (LEVEL !== 5'd1) begin errors++; $display("FAIL simempty_level got %0d exp 1", LEVEL); end
    checks++; if (UNDERFLOW !== 1'b1) begin errors++; $display("FAIL simempty_udf got %b exp 1", UNDERFLOW); end
    checks++; if (DATA_OUT !== 8'h77) begin errors++; $display("FAIL simempty_head got %h exp 77", DATA_OUT); end
    cycle(1'b0, 1'b1, 8'h00);
    ERR_CLEAR = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    ERR_CLEAR = 1'b0;
    checks++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin errors++; $display("FAIL clear_flags got %b%b exp 00", OVERFLOW, UNDERFLOW); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] nxt = 8'h10;
    for (int i = 0; i < 4; i++) begin
      q.push_back(nxt);
      cycle(1'b1, 1'b0, nxt);
      nxt++;
    end
    for (int k = 0; k < 40; k++) begin
      if (k % 4 < 2) begin
        q.push_back(nxt);
        cycle(1'b1, 1'b0, nxt);
        nxt++;
      end else begin
        checks++; if (DATA_OUT !== q[0]) begin errors++; $display("FAIL wrap_data step %0d got %h exp %h", k, DATA_OUT, q[0]); end
        void'(q.pop_front());
        cycle(1'b0, 1'b1, 8'h00);
      end
      checks++; if (LEVEL !== 5'(q.size())) begin errors++; $display("FAIL wrap_level step %0d got %0d exp %0d", k, LEVEL, q.size()); end
    end
    while (q.size() > 0) begin
      checks++; if (DATA_OUT !== q[0]) begin errors++; $display("FAIL wrap_tail got %h exp %h", DATA_OUT, q[0]); end
      void'(q.pop_front());
      cycle(1'b0, 1'b1, 8'h00);
    end
    checks++; if (DATA_READY !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", DATA_READY); end
  endtask

  task automatic test_flush_clear();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
    checks++; if (LEVEL !== 5'd9) begin errors++; $display("FAIL flush_pre got %0d exp 9", LEVEL); end
    FLUSH = 1'b1;
    cycle(1'b1, 1'b1, 8'hDD);
    FLUSH = 1'b0;
    checks++; if (LEVEL !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", LEVEL); end
    checks++; if (DATA_READY !== 1'b0 || DATA_OUT !== 8'h00) begin errors++; $display("FAIL flush_ready got %b/%h exp 0/00", DATA_READY, DATA_OUT); end
    cycle(1'b1, 1'b0, 8'h5A);
    checks++; if (DATA_OUT !== 8'h5A || LEVEL !== 5'd1) begin errors++; $display("FAIL flush_after got %h/%0d exp 5a/1", DATA_OUT, LEVEL); end
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'hFF);
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", OVERFLOW); end
    ERR_CLEAR = 1'b1;
    cycle(1'b1, 1'b0, 8'hFF);
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_priority got %b exp 1", OVERFLOW); end
    cycle(1'b0, 1'b0, 8'h00);
    ERR_CLEAR = 1'b0;
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", OVERFLOW); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 8'h99);
    checks++; if (FULL !== 1'b1 || OVERFLOW !== 1'b1) begin errors++; $display("FAIL mid_pre got %b%b exp 11", FULL, OVERFLOW); end
    FLUSH = 1'b1;
    DATA_STROBE = 1'b1;
    do_reset();
    FLUSH = 1'b0;
    DATA_STROBE = 1'b0;
    checks++; if (LEVEL !== 5'd0 || DATA_READY !== 1'b0 || FULL !== 1'b0) begin errors++; $display("FAIL mid_level got %0d/%b/%b exp 0/0/0", LEVEL, DATA_READY, FULL); end
    checks++; if (ALMOST_FULL !== 1'b0 || ALMOST_EMPTY !== 1'b1) begin errors++; $display("FAIL mid_thr got %b%b exp 01", ALMOST_FULL, ALMOST_EMPTY); end
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL mid_dout got %h exp 00", DATA_OUT); end
    checks++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b exp 00", OVERFLOW, UNDERFLOW); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_simultaneous();
    test_wrap();
    test_flush_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
